control_unit: RTL and testbench

- Multicycle control FSM sitting directly upstream of the 64-bit RISC-V datapath; drives every datapath control input.
- Decodes opcode/funct bits taken from the datapath instruction register.
- Sequences each instruction through FETCH/DECODE/EXEC (+MEM/WB where needed).
- Provides a run gate, an illegal-opcode halt, and a retired-instruction counter.

---
 rtl/control_unit_if.sv | 41 ++++
 rtl/control_unit.sv | 191 +++++++++++++++++++
 tb/tb_control_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/control_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : control_unit_if
// Purpose : Instruction fields in, datapath control strobes out, for the
//           multicycle RV64 control unit.
// Rev     : 1.0 - initial release
// ============================================================================
interface control_unit_if #(
    parameter int CNT_W = 32
);
    logic             run;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             funct7_5;
    logic             sub;
    logic             WE_RF;
    logic             WE_MEM;
    logic [1:0]       RF_din_sel;
    logic             ULA_din2_sel;
    logic             load_pc;
    logic             reset_pc;
    logic             pc_next_sel;
    logic             pc_adder_sel;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    // The control unit is the master and drives the controls.
    modport master (
        input  run, opcode, funct3, funct7_5,
        output sub, WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel, load_pc,
               reset_pc, pc_next_sel, pc_adder_sel, illegal, retired
    );

    // The datapath side supplies the instruction fields.
    modport slave (
        output run, opcode, funct3, funct7_5,
        input  sub, WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel, load_pc,
               reset_pc, pc_next_sel, pc_adder_sel, illegal, retired
    );
endinterface
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module  : control_unit
// Purpose : Multicycle FETCH/DECODE/EXEC(/MEM/WB) sequencer for the RV64
//           datapath, with run gate, illegal-opcode halt and retire counter.
// Rev     : 1.0 - initial release
// ============================================================================
module control_unit #(
    parameter int CNT_W = 32
) (
    input  wire logic       CLK,
    input  wire logic       RST,
    control_unit_if.master  bus
);

    typedef enum logic [2:0] {
        RST_S  = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL, CL_JALR, CL_AUIPC, CL_BAD
    } class_t;

    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_i      = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;

    state_t           r_state;
    state_t           w_next;
    class_t           w_class;
    logic [CNT_W-1:0] r_retired;
    logic             w_retire;

    logic             w_sub;
    logic             w_we_rf;
    logic             w_we_mem;
    logic [1:0]       w_rf_din_sel;
    logic             w_din2_sel;
    logic             w_load_pc;
    logic             w_reset_pc;
    logic             w_pc_next_sel;
    logic             w_pc_adder_sel;
    logic             w_illegal;

    always_comb begin
        w_class = CL_BAD;
        case (bus.opcode)
            c_op_r:      w_class = CL_R;
            c_op_i:      w_class = CL_I;
            c_op_load:   w_class = CL_LOAD;
            c_op_store:  w_class = CL_STORE;
            c_op_branch: w_class = CL_BRANCH;
            c_op_jal:    w_class = CL_JAL;
            c_op_jalr:   w_class = CL_JALR;
            c_op_auipc:  w_class = CL_AUIPC;
            default:     w_class = CL_BAD;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state   <= RST_S;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    always_comb begin
        w_next         = r_state;
        w_sub          = 1'b0;
        w_we_rf        = 1'b0;
        w_we_mem       = 1'b0;
        w_rf_din_sel   = 2'b00;
        w_din2_sel     = 1'b0;
        w_load_pc      = 1'b0;
        w_reset_pc     = 1'b0;
        w_pc_next_sel  = 1'b0;
        w_pc_adder_sel = 1'b0;
        w_illegal      = 1'b0;

        // ALU operand steering must stay stable from decode through memory access.
        if (r_state == DECODE || r_state == EXEC || r_state == MEM) begin
            w_din2_sel = (w_class == CL_I) || (w_class == CL_LOAD) ||
                         (w_class == CL_STORE) || (w_class == CL_JALR);
            w_sub      = (w_class == CL_BRANCH) ||
                         ((w_class == CL_R) && (bus.funct3 == 3'b000) && bus.funct7_5);
        end

        case (r_state)
            RST_S: begin
                w_reset_pc = 1'b1;
                w_next     = FETCH;
            end
            FETCH: begin
                if (bus.run) begin
                    w_next = DECODE;
                end
            end
            DECODE: begin
                w_next = (w_class == CL_BAD) ? HALT : EXEC;
            end
            EXEC: begin
                w_next    = FETCH;
                w_load_pc = 1'b1;
                case (w_class)
                    CL_R, CL_I: begin
                        w_we_rf      = 1'b1;
                        w_rf_din_sel = 2'b01;
                    end
                    CL_AUIPC: begin
                        w_we_rf      = 1'b1;
                        w_rf_din_sel = 2'b11;
                    end
                    CL_STORE: begin
                        w_we_mem = 1'b1;
                    end
                    CL_BRANCH: begin
                        w_pc_next_sel = 1'b1;
                    end
                    CL_JAL: begin
                        w_pc_next_sel = 1'b1;
                        w_next        = WB;
                    end
                    CL_JALR: begin
                        w_pc_next_sel  = 1'b1;
                        w_pc_adder_sel = 1'b1;
                        w_next         = WB;
                    end
                    CL_LOAD: begin
                        w_load_pc = 1'b0;
                        w_next    = MEM;
                    end
                    default: begin
                        w_load_pc = 1'b0;
                        w_next    = HALT;
                    end
                endcase
            end
            MEM: begin
                w_we_rf      = 1'b1;
                w_rf_din_sel = 2'b00;
                w_load_pc    = 1'b1;
                w_next       = FETCH;
            end
            WB: begin
                // PC already advanced in EXEC; the link value is the registered old PC+4.
                w_we_rf      = 1'b1;
                w_rf_din_sel = 2'b10;
                w_next       = FETCH;
            end
            HALT: begin
                w_illegal = 1'b1;
            end
            default: begin
                w_next = RST_S;
            end
        endcase
    end

    assign w_retire = (r_state == EXEC) &&
                      ((w_next == FETCH) || (w_next == MEM) || (w_next == WB));

    assign bus.sub          = w_sub;
    assign bus.WE_RF        = w_we_rf;
    assign bus.WE_MEM       = w_we_mem;
    assign bus.RF_din_sel   = w_rf_din_sel;
    assign bus.ULA_din2_sel = w_din2_sel;
    assign bus.load_pc      = w_load_pc;
    assign bus.reset_pc     = w_reset_pc;
    assign bus.pc_next_sel  = w_pc_next_sel;
    assign bus.pc_adder_sel = w_pc_adder_sel;
    assign bus.illegal      = w_illegal;
    assign bus.retired      = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_control_unit
// Purpose : Directed bench for control_unit; expected values hand-computed.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_control_unit;

    localparam int CNT_W = 32;

    logic CLK;
    logic RST;
    int   n_tests;
    int   n_fail;

    control_unit_if #(.CNT_W(CNT_W)) bus ();

    control_unit #(.CNT_W(CNT_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.master)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Packs expected outputs: sub, WE_RF, WE_MEM, RF_din_sel, din2, load_pc,
    // reset_pc, pc_next_sel, pc_adder_sel, illegal.
    function automatic logic [10:0] o(input logic s, input logic wrf, input logic wmem,
                                      input logic [1:0] rsel, input logic d2, input logic lpc,
                                      input logic rpc, input logic nsel, input logic asel,
                                      input logic ill);
        return {s, wrf, wmem, rsel, d2, lpc, rpc, nsel, asel, ill};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [10:0] exp);
        logic [10:0] obs;
        obs = {bus.sub, bus.WE_RF, bus.WE_MEM, bus.RF_din_sel, bus.ULA_din2_sel,
               bus.load_pc, bus.reset_pc, bus.pc_next_sel, bus.pc_adder_sel, bus.illegal};
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: outputs got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_ret(input string tag, input logic [CNT_W-1:0] exp);
        n_tests++;
        assert (bus.retired === exp) else begin
            n_fail++;
            $error("FAIL %s: retired got %0d expected %0d", tag, bus.retired, exp);
        end
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        bus.opcode   = op;
        bus.funct3   = f3;
        bus.funct7_5 = f7;
    endtask

    localparam logic [10:0] c_zero = 11'b0;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        RST     = 1'b0;
        bus.run = 1'b1;
        set_instr(7'b0000000, 3'b000, 1'b0);

        // Reset held for two edges
        step();
        step();
        chk_out("reset_state", o(0,0,0,2'b00,0,0,1,0,0,0));
        chk_ret("reset_retired", 0);
        RST = 1'b1;
        step();
        chk_out("first_fetch", c_zero);

        // R-type SUB: 3 cycles fetch-to-fetch
        set_instr(7'b0110011, 3'b000, 1'b1);
        step(); chk_out("sub_decode", o(1,0,0,2'b00,0,0,0,0,0,0));
        step(); chk_out("sub_exec",   o(1,1,0,2'b01,0,1,0,0,0,0));
        step(); chk_out("sub_fetch",  c_zero);
        chk_ret("sub_retired", 1);

        // LOAD then STORE back to back: 7 cycles
        set_instr(7'b0000011, 3'b011, 1'b0);
        step(); chk_out("ld_decode", o(0,0,0,2'b00,1,0,0,0,0,0));
        step(); chk_out("ld_exec",   o(0,0,0,2'b00,1,0,0,0,0,0));
        step(); chk_out("ld_mem",    o(0,1,0,2'b00,1,1,0,0,0,0));
        chk_ret("ld_retired", 2);
        step(); chk_out("ld_fetch", c_zero);
        set_instr(7'b0100011, 3'b011, 1'b0);
        step(); chk_out("st_decode", o(0,0,0,2'b00,1,0,0,0,0,0));
        step(); chk_out("st_exec",   o(0,0,1,2'b00,1,1,0,0,0,0));
        step(); chk_out("st_fetch",  c_zero);
        chk_ret("st_retired", 3);

        // JALR: link written in WB after PC moved
        set_instr(7'b1100111, 3'b000, 1'b0);
        step(); chk_out("jalr_decode", o(0,0,0,2'b00,1,0,0,0,0,0));
        step(); chk_out("jalr_exec",   o(0,0,0,2'b00,1,1,0,1,1,0));
        step(); chk_out("jalr_wb",     o(0,1,0,2'b10,0,0,0,0,0,0));
        chk_ret("jalr_retired", 4);
        step(); chk_out("jalr_fetch", c_zero);

        // BRANCH
        set_instr(7'b1100011, 3'b001, 1'b0);
        step(); chk_out("br_decode", o(1,0,0,2'b00,0,0,0,0,0,0));
        step(); chk_out("br_exec",   o(1,0,0,2'b00,0,1,0,1,0,0));
        step(); chk_ret("br_retired", 5);

        // I-ALU with bit 30 set must not subtract
        set_instr(7'b0010011, 3'b000, 1'b1);
        step(); step(); chk_out("addi_exec", o(0,1,0,2'b01,1,1,0,0,0,0));
        step();

        // R-type SRA: funct7_5 set but funct3 != 000 -> no subtract
        set_instr(7'b0110011, 3'b101, 1'b1);
        step(); step(); chk_out("sra_exec", o(0,1,0,2'b01,0,1,0,0,0,0));
        step();

        // AUIPC
        set_instr(7'b0010111, 3'b000, 1'b0);
        step(); step(); chk_out("auipc_exec", o(0,1,0,2'b11,0,1,0,0,0,0));
        step(); chk_ret("auipc_retired", 8);

        // JAL
        set_instr(7'b1101111, 3'b000, 1'b0);
        step(); step(); chk_out("jal_exec", o(0,0,0,2'b00,0,1,0,1,0,0));
        step(); chk_out("jal_wb",   o(0,1,0,2'b10,0,0,0,0,0,0));
        step(); chk_out("jal_fetch", c_zero);
        chk_ret("jal_retired", 9);

        // Illegal opcode halts; run is ignored
        set_instr(7'b1111111, 3'b000, 1'b0);
        step(); chk_out("ill_decode", c_zero);
        step(); chk_out("ill_halt", o(0,0,0,2'b00,0,0,0,0,0,1));
        for (int i = 0; i < 20; i++) begin
            step();
            chk_out("ill_hold", o(0,0,0,2'b00,0,0,0,0,0,1));
        end
        chk_ret("ill_retired", 9);
        RST = 1'b0;
        step(); chk_out("ill_reset", o(0,0,0,2'b00,0,0,1,0,0,0));
        chk_ret("ill_reset_ret", 0);
        RST = 1'b1;
        step(); chk_out("ill_refetch", c_zero);

        // Reset during STORE EXEC
        set_instr(7'b0100011, 3'b010, 1'b0);
        step(); step(); chk_out("st2_exec", o(0,0,1,2'b00,1,1,0,0,0,0));
        RST = 1'b0;
        step(); chk_out("st2_reset", o(0,0,0,2'b00,0,0,1,0,0,0));
        chk_ret("st2_reset_ret", 0);
        RST     = 1'b1;
        bus.run = 1'b0;
        step(); chk_out("stall_fetch", c_zero);
        for (int i = 0; i < 5; i++) begin
            step();
            chk_out("stall_hold", c_zero);
        end
        bus.run = 1'b1;
        step(); chk_out("stall_release", o(0,0,0,2'b00,1,0,0,0,0,0));
        chk_ret("stall_retired", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
